// File: rtl/capture_ctrl.sv
// capture_ctrl: sequences one capture (pre-trigger fill, armed wait, post-trigger count) into a circular RAM.
// Optional timeout-forced trigger when CAPT_AUTO_TRIG_EN is defined.
module capture_ctrl #(
    parameter int ADDR_W = 9,
    parameter int AUTO_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              wrt_smpl,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic              clr_done,
    input  logic [AUTO_W-1:0] auto_to,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              set_armed,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              capture_done,
    output logic              auto_trig
);
    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_e;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, trig_addr_q, tp_q;
    logic [ADDR_W:0]   smpl_cnt_q, post_cnt_q, pre_len, smpl_nxt, post_nxt;
    logic              start, trig_hit, accept;

    assign start    = (state_q == IDLE) && run;
    assign pre_len  = DEPTH - {1'b0, tp_q};
    assign smpl_nxt = smpl_cnt_q + 1'b1;
    assign post_nxt = post_cnt_q + 1'b1;
    assign accept   = (state_q == ARMED) && run && trig_hit;

`ifdef CAPT_AUTO_TRIG_EN
    logic [AUTO_W-1:0] auto_cnt_q;
    logic              auto_trig_q, force_trig;
    assign force_trig = (state_q == ARMED) && we && (auto_to != '0) && (auto_cnt_q + 1'b1 == auto_to);
    assign trig_hit   = trigger | force_trig;
    assign auto_trig  = auto_trig_q;
    // Count is held at zero outside ARMED, so it restarts on every ARMED entry
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_cnt_q  <= '0;
            auto_trig_q <= 1'b0;
        end else begin
            auto_cnt_q  <= (state_q != ARMED) ? '0 : we ? auto_cnt_q + 1'b1 : auto_cnt_q;
            auto_trig_q <= start ? 1'b0 : (accept && !trigger) ? 1'b1 : auto_trig_q;
        end
    end
`else
    logic unused_auto;
    assign unused_auto = ^auto_to;
    assign trig_hit    = trigger;
    assign auto_trig   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = run ? PRE : IDLE;
            PRE:     state_d = !run ? IDLE : (we && smpl_nxt == pre_len) ? ARMED : PRE;
            ARMED:   state_d = !run ? IDLE : !trig_hit ? ARMED : (we && tp_q == ADDR_W'(1)) ? DONE : POST;
            POST:    state_d = !run ? IDLE : (we && post_nxt == {1'b0, tp_q}) ? DONE : POST;
            DONE:    state_d = clr_done ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we           = wrt_smpl && (state_q == PRE || state_q == ARMED || state_q == POST);
        set_armed    = (state_q == ARMED) || (state_q == POST);
        capture_done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            waddr_q     <= '0;
            trig_addr_q <= '0;
            tp_q        <= '0;
            smpl_cnt_q  <= '0;
            post_cnt_q  <= '0;
        end else begin
            if (start) begin
                waddr_q    <= '0;
                smpl_cnt_q <= '0;
                tp_q       <= (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
            end else if (we) begin
                waddr_q <= waddr_q + 1'b1;
            end
            if (state_q == PRE && we) smpl_cnt_q <= smpl_nxt;
            // The write coinciding with the trigger is post sample 1
            if (accept) begin
                trig_addr_q <= waddr_q;
                post_cnt_q  <= {{ADDR_W{1'b0}}, we};
            end else if (state_q == POST && we) begin
                post_cnt_q <= post_nxt;
            end
        end
    end

    assign waddr     = waddr_q;
    assign trig_addr = trig_addr_q;
endmodule

// File: tb/tb_capture_ctrl.sv
// tb_capture_ctrl: directed checks of capture_ctrl with a 16-entry buffer.
module tb_capture_ctrl;
    logic       clk, rst, run, wrt_smpl, trigger, clr_done;
    logic [3:0] trig_pos, waddr, trig_addr;
    logic [15:0] auto_to;
    logic       we, set_armed, capture_done, auto_trig;
    int n_pass = 0, n_total = 0, we_cnt = 0;

    capture_ctrl #(.ADDR_W(4), .AUTO_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .wrt_smpl(wrt_smpl), .trigger(trigger),
        .trig_pos(trig_pos), .clr_done(clr_done), .auto_to(auto_to), .we(we),
        .waddr(waddr), .set_armed(set_armed), .trig_addr(trig_addr),
        .capture_done(capture_done), .auto_trig(auto_trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        if (we === 1'b1) we_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; wrt_smpl = 1'b1; trigger = 1'b0; clr_done = 1'b0;
        trig_pos = 4'd4; auto_to = 16'd0;
        tick();
        rst = 1'b0;
        we_cnt = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (waddr !== 4'd0) $display("FAIL reset_waddr: got %0d want 0", waddr); else n_pass++;
        n_total++; if (trig_addr !== 4'd0) $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); else n_pass++;
        n_total++; if (set_armed !== 1'b0) $display("FAIL reset_set_armed: got %b want 0", set_armed); else n_pass++;
        n_total++; if (capture_done !== 1'b0) $display("FAIL reset_done: got %b want 0", capture_done); else n_pass++;
        n_total++; if (auto_trig !== 1'b0) $display("FAIL reset_auto_trig: got %b want 0", auto_trig); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL reset_we_idle: got %b want 0", we); else n_pass++;
    endtask

    task automatic test_basic_and_restart();
        do_reset();
        run = 1'b1;
        tick();
        ticks(11);
        n_total++; if (set_armed !== 1'b0) $display("FAIL basic_pre_11: got %b want 0", set_armed); else n_pass++;
        tick();
        n_total++; if (set_armed !== 1'b1) $display("FAIL basic_armed_12: got %b want 1", set_armed); else n_pass++;
        n_total++; if (we_cnt !== 12) $display("FAIL basic_pre_writes: got %0d want 12", we_cnt); else n_pass++;
        ticks(7);
        n_total++; if (waddr !== 4'd3) $display("FAIL basic_waddr_wrap: got %0d want 3", waddr); else n_pass++;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        trig_pos = 4'd9;
        n_total++; if (trig_addr !== 4'd3) $display("FAIL basic_trig_addr: got %0d want 3", trig_addr); else n_pass++;
        ticks(2);
        n_total++; if (capture_done !== 1'b0) $display("FAIL basic_early_done: got %b want 0", capture_done); else n_pass++;
        tick();
        n_total++; if (capture_done !== 1'b1) $display("FAIL basic_done: got %b want 1", capture_done); else n_pass++;
        n_total++; if (set_armed !== 1'b0) $display("FAIL basic_done_armed: got %b want 0", set_armed); else n_pass++;
        n_total++; if (we_cnt !== 23) $display("FAIL basic_we_total: got %0d want 23", we_cnt); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL basic_we_in_done: got %b want 0", we); else n_pass++;
        ticks(3);
        n_total++; if (capture_done !== 1'b1) $display("FAIL done_held: got %b want 1", capture_done); else n_pass++;
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
        n_total++; if (capture_done !== 1'b0) $display("FAIL clr_done: got %b want 0", capture_done); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL idle_after_clr_we: got %b want 0", we); else n_pass++;
        tick();
        n_total++; if (we !== 1'b1) $display("FAIL restart_pre_we: got %b want 1", we); else n_pass++;
        n_total++; if (waddr !== 4'd0) $display("FAIL restart_waddr: got %0d want 0", waddr); else n_pass++;
    endtask

    task automatic test_trigger_in_pre();
        do_reset();
        run = 1'b1; trigger = 1'b1;
        tick();
        ticks(11);
        n_total++; if (set_armed !== 1'b0) $display("FAIL pretrig_ignored: got %b want 0", set_armed); else n_pass++;
        tick();
        n_total++; if (set_armed !== 1'b1) $display("FAIL pretrig_armed: got %b want 1", set_armed); else n_pass++;
        tick();
        n_total++; if (trig_addr !== 4'd12) $display("FAIL pretrig_trig_addr: got %0d want 12", trig_addr); else n_pass++;
        ticks(2);
        n_total++; if (capture_done !== 1'b0) $display("FAIL pretrig_early_done: got %b want 0", capture_done); else n_pass++;
        tick();
        n_total++; if (capture_done !== 1'b1) $display("FAIL pretrig_done: got %b want 1", capture_done); else n_pass++;
        n_total++; if (we_cnt !== 16) $display("FAIL pretrig_we_total: got %0d want 16", we_cnt); else n_pass++;
    endtask

    task automatic test_sparse_strobe();
        do_reset();
        run = 1'b1; wrt_smpl = 1'b0;
        tick();
        for (int k = 0; k < 35; k++) begin
            wrt_smpl = (k % 3 == 2);
            tick();
        end
        n_total++; if (set_armed !== 1'b0) $display("FAIL sparse_pre_35: got %b want 0", set_armed); else n_pass++;
        n_total++; if (waddr !== 4'd11) $display("FAIL sparse_waddr_35: got %0d want 11", waddr); else n_pass++;
        wrt_smpl = 1'b1;
        tick();
        wrt_smpl = 1'b0;
        n_total++; if (set_armed !== 1'b1) $display("FAIL sparse_armed_36: got %b want 1", set_armed); else n_pass++;
        n_total++; if (waddr !== 4'd12) $display("FAIL sparse_waddr_36: got %0d want 12", waddr); else n_pass++;
    endtask

    task automatic test_abort_post();
        do_reset();
        run = 1'b1;
        tick();
        ticks(12);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        run = 1'b0;
        tick();
        n_total++; if (set_armed !== 1'b0) $display("FAIL abort_armed: got %b want 0", set_armed); else n_pass++;
        n_total++; if (capture_done !== 1'b0) $display("FAIL abort_done: got %b want 0", capture_done); else n_pass++;
        n_total++; if (trig_addr !== 4'd12) $display("FAIL abort_trig_addr: got %0d want 12", trig_addr); else n_pass++;
        n_total++; if (we_cnt !== 15) $display("FAIL abort_we_total: got %0d want 15", we_cnt); else n_pass++;
        n_total++; if (we !== 1'b0) $display("FAIL abort_idle_we: got %b want 0", we); else n_pass++;
        run = 1'b1;
        tick();
        n_total++; if (waddr !== 4'd0) $display("FAIL abort_restart_waddr: got %0d want 0", waddr); else n_pass++;
        n_total++; if (we !== 1'b1) $display("FAIL abort_restart_we: got %b want 1", we); else n_pass++;
    endtask

    task automatic test_reset_armed();
        do_reset();
        run = 1'b1;
        tick();
        ticks(12);
        trigger = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; run = 1'b0; trigger = 1'b0;
        n_total++; if (waddr !== 4'd0) $display("FAIL rstmid_waddr: got %0d want 0", waddr); else n_pass++;
        n_total++; if (trig_addr !== 4'd0) $display("FAIL rstmid_trig_addr: got %0d want 0", trig_addr); else n_pass++;
        n_total++; if (set_armed !== 1'b0) $display("FAIL rstmid_armed: got %b want 0", set_armed); else n_pass++;
    endtask

    task automatic test_trig_pos_zero();
        do_reset();
        trig_pos = 4'd0; run = 1'b1;
        tick();
        ticks(14);
        n_total++; if (set_armed !== 1'b0) $display("FAIL tp0_pre_14: got %b want 0", set_armed); else n_pass++;
        tick();
        n_total++; if (set_armed !== 1'b1) $display("FAIL tp0_armed_15: got %b want 1", set_armed); else n_pass++;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        n_total++; if (capture_done !== 1'b1) $display("FAIL tp0_done: got %b want 1", capture_done); else n_pass++;
        n_total++; if (trig_addr !== 4'd15) $display("FAIL tp0_trig_addr: got %0d want 15", trig_addr); else n_pass++;
        n_total++; if (we_cnt !== 16) $display("FAIL tp0_we_total: got %0d want 16", we_cnt); else n_pass++;
    endtask

    task automatic test_auto_trigger();
        do_reset();
        auto_to = 16'd8; run = 1'b1;
        tick();
        ticks(12);
        ticks(7);
`ifdef CAPT_AUTO_TRIG_EN
        n_total++; if (auto_trig !== 1'b0) $display("FAIL auto_early: got %b want 0", auto_trig); else n_pass++;
        tick();
        n_total++; if (auto_trig !== 1'b1) $display("FAIL auto_flag: got %b want 1", auto_trig); else n_pass++;
        n_total++; if (trig_addr !== 4'd3) $display("FAIL auto_trig_addr: got %0d want 3", trig_addr); else n_pass++;
        ticks(3);
        n_total++; if (capture_done !== 1'b1) $display("FAIL auto_done: got %b want 1", capture_done); else n_pass++;
`else
        ticks(5);
        n_total++; if (auto_trig !== 1'b0) $display("FAIL auto_tied_off: got %b want 0", auto_trig); else n_pass++;
        n_total++; if (capture_done !== 1'b0) $display("FAIL auto_no_force: got %b want 0", capture_done); else n_pass++;
        n_total++; if (set_armed !== 1'b1) $display("FAIL auto_still_armed: got %b want 1", set_armed); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic_and_restart();
        test_trigger_in_pre();
        test_sparse_strobe();
        test_abort_post();
        test_reset_armed();
        test_trig_pos_zero();
        test_auto_trigger();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
